// File: rtl/i2c_req_arbiter_if.sv
// Requester-side and I2C-master-side signals of the request arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface i2c_req_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ-1:0]   req_rw;
    logic [7*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic [7:0]           rdata;
    logic                 timeout_err;
    logic                 busy;
    logic                 m_ena;
    logic                 m_rw;
    logic [6:0]           m_address;
    logic [7:0]           m_data_in;
    logic                 m_valid;
    logic [7:0]           m_data_out;

    modport master (
        input  req, req_rw, req_addr, req_wdata, m_valid, m_data_out,
        output gnt, done, rdata, timeout_err, busy, m_ena, m_rw, m_address, m_data_in
    );

    modport slave (
        output req, req_rw, req_addr, req_wdata, m_valid, m_data_out,
        input  gnt, done, rdata, timeout_err, busy, m_ena, m_rw, m_address, m_data_in
    );
endinterface

// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C master between NUM_REQ requesters.
// Latches the winner's command, waits for the master's valid pulse (or a
// timeout), returns done/rdata to the owner and forces a one-cycle ena gap.
module i2c_req_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned TO_W           = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    i2c_req_arbiter_if.master  bus
);
    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {StIdle, StBusy, StRelease} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               to_q, to_d;
    logic               busy_q, busy_d;
    logic               ena_q, ena_d;
    logic               rw_q, rw_d;
    logic [6:0]         addr_q, addr_d;
    logic [7:0]         wdata_q, wdata_d;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;

    // Round-robin pick: first set req bit searching upward from ptr+1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!win_found && bus.req[(32'(ptr_q) + k) % NUM_REQ]) begin
                win_found = 1'b1;
                win_idx   = PTR_W'((32'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        rdata_d = rdata_q;
        to_d    = 1'b0;
        ena_d   = ena_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StBusy;
                    gnt_d   = NUM_REQ'(1) << win_idx;
                    ena_d   = 1'b1;
                    rw_d    = bus.req_rw[win_idx];
                    addr_d  = bus.req_addr[7*win_idx +: 7];
                    wdata_d = bus.req_wdata[8*win_idx +: 8];
                    ptr_d   = win_idx;
                    cnt_d   = '0;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + 1'b1;
                // Valid takes precedence over a coincident timeout.
                if (bus.m_valid) begin
                    state_d = StRelease;
                    ena_d   = 1'b0;
                    gnt_d   = '0;
                    done_d  = gnt_q;
                    if (rw_q) rdata_d = bus.m_data_out;
                end else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StRelease;
                    ena_d   = 1'b0;
                    gnt_d   = '0;
                    done_d  = gnt_q;
                    to_d    = 1'b1;
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            rdata_q <= '0;
            to_q    <= 1'b0;
            busy_q  <= 1'b0;
            ena_q   <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            to_q    <= to_d;
            busy_q  <= busy_d;
            ena_q   <= ena_d;
            rw_q    <= rw_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.gnt         = gnt_q;
    assign bus.done        = done_q;
    assign bus.rdata       = rdata_q;
    assign bus.timeout_err = to_q;
    assign bus.busy        = busy_q;
    assign bus.m_ena       = ena_q;
    assign bus.m_rw        = rw_q;
    assign bus.m_address   = addr_q;
    assign bus.m_data_in   = wdata_q;
endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Randomized bench for i2c_req_arbiter with a transaction-level reference model.
module tb_i2c_req_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: last winner and last captured read byte.
    int         m_ptr   = N - 1;
    logic [7:0] m_rdata = 8'h00;

    i2c_req_arbiter_if #(.NUM_REQ(N)) bus ();

    i2c_req_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO),
        .TO_W           (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    function automatic int rr_winner(input logic [N-1:0] r, input int p);
        for (int k = 1; k <= N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic rw, input logic [6:0] a, input logic [7:0] d);
        bus.req[i]            = 1'b1;
        bus.req_rw[i]         = rw;
        bus.req_addr[7*i +: 7] = a;
        bus.req_wdata[8*i +: 8] = d;
    endtask

    // Called at #1 after a clock edge with the DUT idle. delay = BUSY cycle
    // index in which m_valid is raised (>= TO means the master never answers).
    task automatic do_txn(input int delay, input bit hold, input logic [7:0] rd_byte);
        int         w;
        int         e_end;
        bit         e_to;
        logic       e_rw;
        logic [6:0] e_addr;
        logic [7:0] e_wd;
        w = rr_winner(bus.req, m_ptr);
        if (w < 0) begin
            @(posedge clk); #1;
            check_eq("idle_gnt", 32'(bus.gnt), 0);
            check_eq("idle_busy", 32'(bus.busy), 0);
            return;
        end
        e_rw   = bus.req_rw[w];
        e_addr = bus.req_addr[7*w +: 7];
        e_wd   = bus.req_wdata[8*w +: 8];
        @(posedge clk); #1;
        check_eq("gnt", 32'(bus.gnt), 32'(1) << w);
        check_eq("m_ena", 32'(bus.m_ena), 1);
        check_eq("m_rw", 32'(bus.m_rw), 32'(e_rw));
        check_eq("m_address", 32'(bus.m_address), 32'(e_addr));
        check_eq("m_data_in", 32'(bus.m_data_in), 32'(e_wd));
        check_eq("busy", 32'(bus.busy), 1);
        m_ptr = w;
        // Slices are latched at grant, so the requester may change them now.
        bus.req_rw[w]           = 1'($urandom);
        bus.req_addr[7*w +: 7]  = 7'($urandom);
        bus.req_wdata[8*w +: 8] = 8'($urandom);
        if (!hold && ($urandom % 4 == 0)) bus.req[w] = 1'b0;
        e_to  = (delay > TO - 1);
        e_end = e_to ? TO - 1 : delay;
        for (int c = 0; c <= e_end; c++) begin
            bus.m_valid    = (c == delay);
            bus.m_data_out = (c == delay) ? rd_byte : 8'($urandom);
            @(posedge clk); #1;
            if (c < e_end) begin
                check_eq("busy_done", 32'(bus.done), 0);
                check_eq("busy_ena", 32'(bus.m_ena), 1);
                check_eq("busy_addr", 32'(bus.m_address), 32'(e_addr));
            end
        end
        if (!e_to && e_rw) m_rdata = rd_byte;
        check_eq("done", 32'(bus.done), 32'(1) << w);
        check_eq("timeout_err", 32'(bus.timeout_err), 32'(e_to));
        check_eq("rdata", 32'(bus.rdata), 32'(m_rdata));
        check_eq("done_ena", 32'(bus.m_ena), 0);
        check_eq("done_gnt", 32'(bus.gnt), 0);
        check_eq("done_busy", 32'(bus.busy), 1);
        if (!hold) bus.req[w] = 1'b0;
        // A stray valid outside BUSY must be ignored.
        bus.m_valid    = 1'($urandom);
        bus.m_data_out = 8'($urandom);
        @(posedge clk); #1;
        check_eq("rel_done", 32'(bus.done), 0);
        check_eq("rel_to", 32'(bus.timeout_err), 0);
        check_eq("rel_ena", 32'(bus.m_ena), 0);
        check_eq("rel_busy", 32'(bus.busy), 0);
        check_eq("rel_rdata", 32'(bus.rdata), 32'(m_rdata));
        bus.m_valid = 1'b0;
    endtask

    initial begin
        bus.req = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.m_valid = 1'b0; bus.m_data_out = '0;
        #3;
        check_eq("rst_gnt", 32'(bus.gnt), 0);
        check_eq("rst_done", 32'(bus.done), 0);
        check_eq("rst_rdata", 32'(bus.rdata), 0);
        check_eq("rst_to", 32'(bus.timeout_err), 0);
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_ena", 32'(bus.m_ena), 0);
        check_eq("rst_cmd", {bus.m_rw, bus.m_address, bus.m_data_in}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed write, then read.
        set_req(0, 1'b0, 7'd8, 8'd10);
        do_txn(10, 1'b0, 8'h3C);
        set_req(2, 1'b1, 7'h50, 8'h00);
        do_txn(5, 1'b0, 8'hA5);
        check_eq("read_a5", 32'(bus.rdata), 32'hA5);

        // Contention: all four, then 0 and 3 held.
        for (int i = 0; i < N; i++) set_req(i, 1'(i), 7'(i + 1), 8'(i * 3));
        for (int t = 0; t < N; t++) do_txn(2, 1'b0, 8'(t));
        set_req(0, 1'b0, 7'h11, 8'h22);
        set_req(3, 1'b1, 7'h33, 8'h44);
        for (int t = 0; t < 4; t++) do_txn(1, 1'b1, 8'(8'h90 + t));
        bus.req = '0;

        // Timeout, then coincident valid/timeout on a read.
        set_req(1, 1'b1, 7'h2A, 8'h55);
        do_txn(TO + 4, 1'b0, 8'hEE);
        set_req(1, 1'b1, 7'h2B, 8'h66);
        do_txn(TO - 1, 1'b0, 8'h7E);

        // Reset mid-BUSY with requester 3 owning the master.
        set_req(3, 1'b0, 7'h40, 8'h01);
        @(posedge clk); #1;
        check_eq("pre_rst_gnt", 32'(bus.gnt), 32'b1000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_gnt", 32'(bus.gnt), 0);
        check_eq("arst_ena", 32'(bus.m_ena), 0);
        check_eq("arst_busy", 32'(bus.busy), 0);
        check_eq("arst_done", 32'(bus.done), 0);
        m_ptr = N - 1; m_rdata = 8'h00;
        set_req(0, 1'b1, 7'h05, 8'h00);
        set_req(3, 1'b0, 7'h41, 8'h02);
        @(posedge clk); #1;
        check_eq("arst_done2", 32'(bus.done), 0);
        rst_n = 1'b1;
        do_txn(3, 1'b0, 8'hC3);
        do_txn(4, 1'b0, 8'h00);

        // Randomized traffic.
        for (int t = 0; t < 80; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i] && ($urandom % 2 == 1))
                    set_req(i, 1'($urandom), 7'($urandom), 8'($urandom));
            end
            do_txn(($urandom % 4 == 0) ? int'($urandom_range(TO - 2, TO + 6))
                                       : int'($urandom_range(0, 12)),
                   ($urandom % 5 == 0), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
